// File: rtl/inst_resp.sv
`default_nettype none
//============================================================================
//  Module   : inst_resp
//  Purpose  : Instruction-fetch responder with a single-entry line buffer.
//             It folds virtual fetch addresses onto physical memory with
//             ADDR_MASK and answers hits in one cycle, like a synchronous
//             ROM. A miss issues a single read strobe to backing memory and
//             waits up to TIMEOUT cycles for the answer. If the requester
//             redirects while a read is outstanding, the stale answer is
//             drained and dropped before the new read is issued.
//
//  Ports    : clk        - sole clock, rising edge
//             resetn     - asynchronous active-low reset
//             req        - fetch request, inst_addr sampled when high
//             inst_addr  - virtual fetch PC
//             buf_inv    - one-cycle invalidate of the line buffer
//             inst       - returned instruction word
//             inst_ready - inst/addr_err/bus_err valid for last request
//             addr_err   - accepted address was not word aligned
//             bus_err    - memory did not answer within TIMEOUT cycles
//             mem_en     - one-cycle read strobe to backing memory
//             mem_addr   - physical word address of the read
//             mem_rdata  - backing memory read data
//             mem_rvalid - mem_rdata valid, exactly one per mem_en
//
//  Revision : 1.0 - initial release
//============================================================================
module inst_resp #(
    parameter logic [7:0]  TIMEOUT   = 8'd255,
    parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [31:0] inst_addr,
    input  logic        buf_inv,
    output logic [31:0] inst,
    output logic        inst_ready,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;  // no read outstanding
    localparam logic [1:0] c_ST_MISS  = 2'd1;  // read outstanding for r_pend_addr
    localparam logic [1:0] c_ST_DRAIN = 2'd2;  // stale read outstanding, r_next_addr waiting

    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [7:0]  c_CNT_MAX   = 8'hFF;

    logic [1:0]  r_state;
    logic [31:0] r_pend_addr;   // virtual address of the read in flight
    logic [31:0] r_next_addr;   // redirect target captured while draining
    logic [7:0]  r_cnt;         // cycles spent waiting on memory
    logic        r_buf_valid;
    logic [29:0] r_buf_tag;
    logic [31:0] r_buf_data;

    logic        w_misal;
    logic        w_hit;
    logic        w_new_req;
    logic        w_timeout;
    logic [7:0]  w_cnt_sat;
    logic [31:0] w_req_phys;
    logic [31:0] w_next_phys;
    logic        w_next_misal;

    assign w_misal      = (inst_addr[1:0] != 2'b00);
    assign w_hit        = r_buf_valid && (r_buf_tag == inst_addr[31:2]);
    // Only a request for a different address redirects an outstanding miss;
    // repeating the pending address is treated as the same fetch.
    assign w_new_req    = req && (inst_addr != r_pend_addr);
    // Fires on the edge where the wait reaches TIMEOUT cycles.
    assign w_timeout    = ({1'b0, r_cnt} + 9'd1) >= {1'b0, TIMEOUT};
    assign w_cnt_sat    = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 8'd1;
    assign w_req_phys   = inst_addr & ADDR_MASK & c_WORD_MASK;
    assign w_next_phys  = r_next_addr & ADDR_MASK & c_WORD_MASK;
    assign w_next_misal = (r_next_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_ST_IDLE;
            r_pend_addr <= 32'd0;
            r_next_addr <= 32'd0;
            r_cnt       <= 8'd0;
            r_buf_valid <= 1'b0;
            r_buf_tag   <= 30'd0;
            r_buf_data  <= 32'd0;
            inst        <= 32'd0;
            inst_ready  <= 1'b0;
            addr_err    <= 1'b0;
            bus_err     <= 1'b0;
            mem_en      <= 1'b0;
            mem_addr    <= 32'd0;
        end else begin
            // The read strobe is a single-cycle pulse.
            mem_en <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    // Any memory answer arriving here is stale and ignored.
                    if (req) begin
                        if (w_misal) begin
                            inst       <= 32'd0;
                            inst_ready <= 1'b1;
                            addr_err   <= 1'b1;
                            bus_err    <= 1'b0;
                        end else if (w_hit) begin
                            inst       <= r_buf_data;
                            inst_ready <= 1'b1;
                            addr_err   <= 1'b0;
                            bus_err    <= 1'b0;
                        end else begin
                            inst_ready  <= 1'b0;
                            addr_err    <= 1'b0;
                            bus_err     <= 1'b0;
                            mem_en      <= 1'b1;
                            mem_addr    <= w_req_phys;
                            r_pend_addr <= inst_addr;
                            r_cnt       <= 8'd0;
                            r_state     <= c_ST_MISS;
                        end
                    end
                end

                c_ST_MISS: begin
                    r_cnt <= w_cnt_sat;
                    if (mem_rvalid && w_new_req) begin
                        // The old answer lands on the same edge as the
                        // redirect: drop it and serve the new address
                        // directly, with no drain needed.
                        if (w_misal) begin
                            inst       <= 32'd0;
                            inst_ready <= 1'b1;
                            addr_err   <= 1'b1;
                            bus_err    <= 1'b0;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            mem_en      <= 1'b1;
                            mem_addr    <= w_req_phys;
                            r_pend_addr <= inst_addr;
                            r_cnt       <= 8'd0;
                        end
                    end else if (mem_rvalid) begin
                        inst        <= mem_rdata;
                        inst_ready  <= 1'b1;
                        addr_err    <= 1'b0;
                        bus_err     <= 1'b0;
                        r_buf_valid <= 1'b1;
                        r_buf_tag   <= r_pend_addr[31:2];
                        r_buf_data  <= mem_rdata;
                        r_state     <= c_ST_IDLE;
                    end else if (w_new_req) begin
                        // Keep waiting for the old answer so that only one
                        // read is ever outstanding. The counter keeps
                        // running so a dead memory still ends in bus_err.
                        r_next_addr <= inst_addr;
                        r_state     <= c_ST_DRAIN;
                    end else if (w_timeout) begin
                        inst       <= 32'd0;
                        inst_ready <= 1'b1;
                        addr_err   <= 1'b0;
                        bus_err    <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end
                end

                c_ST_DRAIN: begin
                    r_cnt <= w_cnt_sat;
                    if (mem_rvalid) begin
                        // Stale data is discarded. It is not returned and
                        // not written to the buffer.
                        if (w_next_misal) begin
                            inst       <= 32'd0;
                            inst_ready <= 1'b1;
                            addr_err   <= 1'b1;
                            bus_err    <= 1'b0;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            mem_en      <= 1'b1;
                            mem_addr    <= w_next_phys;
                            r_pend_addr <= r_next_addr;
                            r_cnt       <= 8'd0;
                            r_state     <= c_ST_MISS;
                        end
                    end else if (w_timeout) begin
                        inst       <= 32'd0;
                        inst_ready <= 1'b1;
                        addr_err   <= 1'b0;
                        bus_err    <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            // This comes last so that it overrides a fill on the same edge.
            // The fill data is still returned on inst.
            if (buf_inv) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_resp.sv
`default_nettype none
//============================================================================
//  Module   : tb_inst_resp
//  Purpose  : Self-checking bench for inst_resp. It runs directed fetch
//             scenarios and then a randomised fetch sequence. The expected
//             results come from a transaction-level model of the
//             single-entry buffer and a latency-programmable memory.
//  Revision : 1.0 - initial release
//============================================================================
module tb_inst_resp;

    localparam logic [7:0]  c_TO   = 8'd8;
    localparam logic [31:0] c_MASK = 32'h1FFF_FFFF;

    logic        clk;
    logic        resetn;
    logic        req;
    logic [31:0] inst_addr;
    logic        buf_inv;
    logic [31:0] inst;
    logic        inst_ready;
    logic        addr_err;
    logic        bus_err;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    inst_resp #(
        .TIMEOUT   (c_TO),
        .ADDR_MASK (c_MASK)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .inst_addr  (inst_addr),
        .buf_inv    (buf_inv),
        .inst       (inst),
        .inst_ready (inst_ready),
        .addr_err   (addr_err),
        .bus_err    (bus_err),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: one buffer entry and the memory behaviour.
    bit          m_valid = 1'b0;
    logic [29:0] m_tag   = 30'd0;
    logic [31:0] m_data  = 32'd0;
    int          mem_lat = 3;
    bit          mem_drop = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] p);
        if (p == 32'h1FC0_0000) return 32'h3C1D_0001;
        return (p * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] phys(input logic [31:0] v);
        return v & c_MASK & 32'hFFFF_FFFC;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Backing memory: answers each strobe after mem_lat cycles, unless
    // mem_drop is set. A pending answer survives a DUT reset.
    initial begin
        int          cd;
        logic [31:0] d;
        cd = 0;
        d  = 32'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = d;
                end
            end
            if (mem_en && !mem_drop) begin
                cd = mem_lat;
                d  = mem_word(mem_addr);
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, ".inst"},       inst,              32'd0);
        check({tag, ".inst_ready"}, 32'(inst_ready),   32'd0);
        check({tag, ".addr_err"},   32'(addr_err),     32'd0);
        check({tag, ".bus_err"},    32'(bus_err),      32'd0);
        check({tag, ".mem_en"},     32'(mem_en),       32'd0);
        check({tag, ".mem_addr"},   mem_addr,          32'd0);
    endtask

    task automatic invalidate();
        @(negedge clk);
        buf_inv = 1'b1;
        @(negedge clk);
        buf_inv = 1'b0;
        m_valid = 1'b0;
    endtask

    // One fetch transaction. If want_intr is set and a is a plain aligned
    // miss, b is presented one cycle later while the read is in flight.
    // If inv_fill is set on a plain miss, buf_inv coincides with the fill.
    task automatic run_fetch(input string tag, input logic [31:0] a, input bit want_intr,
                             input logic [31:0] b, input bit inv_fill);
        bit          hit_a, second, intr, got, fills;
        logic [31:0] e_inst, e_ma, last_ma;
        bit          e_ae, e_be;
        int          e_en, e_lat, cyc, ens, inv_cyc;

        hit_a  = m_valid && (m_tag == a[31:2]) && (a[1:0] == 2'b00);
        second = want_intr && (a[1:0] == 2'b00) && !hit_a && !mem_drop;
        intr   = second && (b != a);
        fills  = 1'b0;
        e_ma   = phys(a);
        inv_cyc = -1;

        if (intr) begin
            if (b[1:0] != 2'b00) begin
                e_inst = 32'd0; e_ae = 1'b1; e_be = 1'b0; e_en = 1; e_lat = mem_lat + 1;
            end else begin
                e_inst = mem_word(phys(b)); e_ae = 1'b0; e_be = 1'b0; e_en = 2;
                e_lat = 2 * mem_lat + 2; e_ma = phys(b); fills = 1'b1;
            end
        end else if (a[1:0] != 2'b00) begin
            e_inst = 32'd0; e_ae = 1'b1; e_be = 1'b0; e_en = 0; e_lat = 0;
        end else if (hit_a) begin
            e_inst = m_data; e_ae = 1'b0; e_be = 1'b0; e_en = 0; e_lat = 0;
        end else if (mem_drop) begin
            e_inst = 32'd0; e_ae = 1'b0; e_be = 1'b1; e_en = 1; e_lat = int'(c_TO);
        end else begin
            e_inst = mem_word(phys(a)); e_ae = 1'b0; e_be = 1'b0; e_en = 1;
            e_lat = mem_lat + 1; fills = 1'b1;
            if (inv_fill && !second) inv_cyc = mem_lat;
        end

        @(negedge clk);
        req       = 1'b1;
        inst_addr = a;
        @(negedge clk);
        if (second) inst_addr = b;
        else        req = 1'b0;

        cyc = 0; ens = 0; got = 1'b0; last_ma = 32'd0;
        while (1) begin
            if (mem_en) begin
                ens++;
                last_ma = mem_addr;
            end
            if (inst_ready) begin
                got = 1'b1;
                break;
            end
            if (cyc >= 60) break;
            @(negedge clk);
            cyc++;
            if (cyc == 1) req = 1'b0;
            buf_inv = (cyc == inv_cyc);
        end
        req     = 1'b0;
        buf_inv = 1'b0;

        check({tag, ".ready"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, ".inst"},     inst,          e_inst);
            check({tag, ".addr_err"}, 32'(addr_err), 32'(e_ae));
            check({tag, ".bus_err"},  32'(bus_err),  32'(e_be));
            check({tag, ".latency"},  32'(cyc),      32'(e_lat));
        end
        check({tag, ".mem_en_cnt"}, 32'(ens), 32'(e_en));
        if (e_en > 0) check({tag, ".mem_addr"}, last_ma, e_ma);

        if (fills) begin
            m_valid = (inv_cyc < 0);
            m_tag   = intr ? b[31:2] : a[31:2];
            m_data  = e_inst;
        end
    endtask

    initial begin
        int          bad;
        logic [31:0] a, b;
        bit          wi, wf;

        resetn    = 1'b1;
        req       = 1'b0;
        inst_addr = 32'd0;
        buf_inv   = 1'b0;

        // Reset forces every output low immediately, before any clock edge.
        #2 resetn = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Boot fetch: miss, latency-3 memory.
        mem_lat = 3;
        run_fetch("boot_miss", 32'hBFC0_0000, 1'b0, 32'd0, 1'b0);

        // The response holds while no new request arrives.
        repeat (2) @(negedge clk);
        check("hold.inst_ready", 32'(inst_ready), 32'd1);
        check("hold.inst",       inst,            32'h3C1D_0001);

        run_fetch("boot_hit", 32'hBFC0_0000, 1'b0, 32'd0, 1'b0);
        run_fetch("misaligned", 32'hBFC0_0002, 1'b0, 32'd0, 1'b0);
        run_fetch("redirect", 32'hBFC0_0004, 1'b1, 32'hBFC0_0010, 1'b0);
        run_fetch("repeat_pending", 32'hBFC0_0020, 1'b1, 32'hBFC0_0020, 1'b0);
        run_fetch("redirect_misal", 32'hBFC0_0030, 1'b1, 32'hBFC0_0031, 1'b0);

        // Memory never answers: bus error after TIMEOUT cycles, then a retry
        // of the same address misses again.
        mem_drop = 1'b1;
        run_fetch("timeout", 32'hBFC0_0040, 1'b0, 32'd0, 1'b0);
        mem_drop = 1'b0;
        run_fetch("timeout_retry", 32'hBFC0_0040, 1'b0, 32'd0, 1'b0);

        // An invalidate forces a refetch of a previously buffered word.
        run_fetch("prefill", 32'hBFC0_0000, 1'b0, 32'd0, 1'b0);
        invalidate();
        run_fetch("after_inv", 32'hBFC0_0000, 1'b0, 32'd0, 1'b0);

        // An invalidate coincident with a fill: data returned, entry invalid.
        run_fetch("inv_at_fill", 32'h8000_1000, 1'b0, 32'd0, 1'b1);
        run_fetch("inv_at_fill_re", 32'h8000_1000, 1'b0, 32'd0, 1'b0);

        // Reset in the middle of a miss. The late answer must be ignored
        // and the buffer must be empty afterwards.
        mem_lat = 4;
        @(negedge clk);
        req       = 1'b1;
        inst_addr = 32'hBFC0_0200;
        @(negedge clk);
        req = 1'b0;
        check("rst_mid.mem_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1 check_reset("rst_mid");
        m_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (inst_ready || mem_en) bad++;
        end
        check("rst_mid.late_rvalid", 32'(bad), 32'd0);
        run_fetch("rst_mid.refetch", 32'h8000_1000, 1'b0, 32'd0, 1'b0);

        // Randomised fetch sequence over a small address pool, so that both
        // hits and kseg0/kseg1 aliases of the same physical word occur.
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 1) != 0 ? 32'hA000_0000 : 32'h8000_0000)
                | 32'h0000_1000 | (32'($urandom_range(0, 5)) << 2);
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            b = 32'hA000_1000 | (32'($urandom_range(0, 5)) << 2);
            if ($urandom_range(0, 3) == 0) b[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) b = a;
            mem_lat  = int'($urandom_range(1, 5));
            mem_drop = ($urandom_range(0, 9) == 0);
            wi = ($urandom_range(0, 3) == 0);
            wf = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) invalidate();
            run_fetch($sformatf("rnd%0d", i), a, wi, b, wf);
            mem_drop = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
